// File: rtl/aes_pkg.sv
// Shared AES-128 decryption constants, FSM state type, inverse S-box and GF(2^8) helpers.
package aes_pkg;

    localparam int NR      = 10;
    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Inverse S-box, entry x at bits [2047-8x -: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sub(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               last,
    output logic [BLOCK_W-1:0] next_state
);

    logic [BLOCK_W-1:0] keyed;
    logic [BLOCK_W-1:0] mixed;

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // Row r moves right by r columns; byte substitution and key add fused per byte.
    always_comb begin
        keyed = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                keyed[127 - 8 * (c * 4 + r) -: 8] =
                    inv_sub(state[127 - 8 * (((c + 4 - r) % 4) * 4 + r) -: 8])
                    ^ round_key[127 - 8 * (c * 4 + r) -: 8];
            end
        end
    end

    // Column mixing on the keyed state.
    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32 * c -: 32] = inv_mix_col(keyed[127 - 32 * c -: 32]);
        end
    end

    assign next_state = last ? keyed : mixed;

endmodule

// File: rtl/decryption.sv
// Iterative AES-128 decryption core: one inverse round per clock, round keys
// supplied cycle by cycle on key_in in reverse schedule order.
//
// state | meaning
// IDLE  | waiting for start, ready_dec=1
// ROUND | applying inverse rounds, counter counts down to the final round
// DONE  | plain_text valid, done_dec pulses; start here chains a new block
module decryption #(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] cipher_text,
    input  logic [127:0] key_in,
    input  logic         start,
    output logic [127:0] plain_text,
    output logic         ready_dec,
    output logic         done_dec
);
    import aes_pkg::*;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] round_out;
    logic         last;

    assign last = (cnt_q == 4'd0);

    aes_inv_round u_round (
        .state      (blk_q),
        .round_key  (key_in),
        .last       (last),
        .next_state (round_out)
    );

    // Next-state logic; start is only honoured while not in ROUND.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        pt_d    = pt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ROUND;
                    cnt_d   = 4'(NR - 1);
                    blk_d   = cipher_text ^ key_in;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            ROUND: begin
                blk_d = round_out;
                if (last) begin
                    state_d = DONE;
                    pt_d    = round_out;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            pt_q    <= pt_d;
        end
    end

    assign plain_text = pt_q;
    assign ready_dec  = (state_q != ROUND);
    assign done_dec   = (state_q == DONE);

endmodule

// File: tb/tb_decryption.sv
// Bench for the decryption core: known vectors, protocol corner cases and random
// blocks encrypted by an independent forward AES model.
module tb_decryption;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] cipher_text;
    logic [127:0] key_in;
    logic [127:0] plain_text;
    logic         ready_dec;
    logic         done_dec;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rks  [2][11];

    decryption #(.NR(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .cipher_text (cipher_text),
        .key_in      (key_in),
        .start       (start),
        .plain_text  (plain_text),
        .ready_dec   (ready_dec),
        .done_dec    (done_dec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from the field inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, r, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r = inv;
            s = inv;
            for (int n = 0; n < 4; n++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox[x] = s ^ 8'h63;
        end
    endtask

    task automatic load_key(input int slot, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            rks[slot][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input int slot, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] v;
        v = pt ^ rks[slot][0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[v[127 - 8 * i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[c*4 + r] = s[((c + r) % 4) * 4 + r];
            for (int c = 0; c < 4; c++) begin
                a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
                if (rnd < 10) begin
                    s[c*4]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                    s[c*4+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
                    s[c*4+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
                    s[c*4+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
                end else begin
                    s[c*4] = a0; s[c*4+1] = a1; s[c*4+2] = a2; s[c*4+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) v[127 - 8 * i -: 8] = s[i];
            v = v ^ rks[slot][rnd];
        end
        return v;
    endfunction

    // Entered #1 after a rising edge with the core able to accept start.
    // On normal completion returns inside the done_dec cycle.
    task automatic run_op(input int slot, input logic [127:0] ct, input logic [127:0] exp_pt,
                          input string tag, input int restart_k, input int reset_k);
        logic [127:0] pt_prev;
        logic         seen;
        pt_prev = plain_text;
        chk({tag, " ready_at_start"}, ready_dec, 1'b1);
        start       = 1'b1;
        cipher_text = ct;
        key_in      = rks[slot][10];
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk({tag, " busy_flags"}, {ready_dec, done_dec}, 2'b00);
            if (k == 9) chk({tag, " pt_stable"}, plain_text, pt_prev);
            start = (k == restart_k);
            if (k == restart_k) cipher_text = {$urandom, $urandom, $urandom, $urandom};
            key_in = rks[slot][10 - k];
            if (k == reset_k) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                start = 1'b0;
                chk({tag, " abort_done"}, done_dec, 1'b0);
                chk({tag, " abort_pt"}, plain_text, '0);
                chk({tag, " abort_ready"}, ready_dec, 1'b1);
                seen = 1'b0;
                for (int i = 0; i < 12; i++) begin
                    @(posedge clk); #1;
                    seen = seen | done_dec;
                end
                chk({tag, " abort_no_done"}, seen, 1'b0);
                return;
            end
        end
        @(posedge clk); #1;
        chk({tag, " done"}, done_dec, 1'b1);
        chk({tag, " pt"}, plain_text, exp_pt);
        chk({tag, " ready_in_done"}, ready_dec, 1'b1);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                chk("done_one_cycle", done_dec, 1'b0);
                chk("idle_ready", ready_dec, 1'b1);
            end
        end
    endtask

    initial begin
        logic [127:0] pt_r, ct_r;
        reset       = 1'b1;
        start       = 1'b1;
        cipher_text = 128'h0;
        key_in      = 128'h0;
        build_sbox();
        @(negedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_beats_start_ready", ready_dec, 1'b1);
        reset = 1'b0;
        start = 1'b0;
        chk("reset_pt", plain_text, '0);
        chk("reset_done", done_dec, 1'b0);
        @(posedge clk); #1;
        chk("reset_idle_ready", ready_dec, 1'b1);

        load_key(0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_op(0, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, "fips_a", -1, -1);
        idle(2);
        run_op(0, 128'h8df4e9aac5c7573a27d8d055d6e4d64b, 128'h00112233445566778899aabbccddeeff, "same_key", -1, -1);
        idle(2);
        load_key(1, 128'h000102030405060708090a0b0c0d0e0f);
        run_op(1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, "fips_c", -1, -1);
        idle(2);
        run_op(0, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, "restart_ignored", 4, -1);
        idle(2);
        run_op(1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h0, "mid_reset", -1, 5);
        run_op(1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, "after_reset", -1, -1);
        idle(2);
        run_op(0, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, "b2b_first", -1, -1);
        run_op(1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, "b2b_second", -1, -1);
        idle(2);

        for (int i = 0; i < 8; i++) begin
            load_key(0, {$urandom, $urandom, $urandom, $urandom});
            pt_r = {$urandom, $urandom, $urandom, $urandom};
            ct_r = encrypt(0, pt_r);
            run_op(0, ct_r, pt_r, "random", -1, -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
